// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode and FSM state encodings,
// counter width, and the "is this a long-latency op" helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int CNT_W = 4;

  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for mult/div, including divide-overflow and
// divide-by-zero handling. Optional build macro: MDU_DIVZERO_KEEP_EN.
import mdu_pkg::*;

module mdu_arith (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        res_wr
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    res_wr = 1'b1;
    case (op)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
`ifdef MDU_DIVZERO_KEEP_EN
          res_wr = 1'b0;
`else
          lo_res = 32'hFFFF_FFFF;
          hi_res = a;
`endif
        end else if (op == MD_DIVU) begin
          lo_res = a / b;
          hi_res = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // Quotient +2^31 is unrepresentable; wrap it and force a zero remainder.
          lo_res = 32'h8000_0000;
          hi_res = 32'd0;
        end else begin
          lo_res = $signed(a) / $signed(b);
          hi_res = $signed(a) % $signed(b);
        end
      end
      default: res_wr = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO; sequences a fixed busy window
// and raises the pipeline stall request. Optional build macro: MDU_DIVZERO_KEEP_EN.
import mdu_pkg::*;

module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        done,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2:0]         op_reg;
  logic [31:0]        a_reg;
  logic [31:0]        b_reg;
  logic [31:0]        hi_reg;
  logic [31:0]        lo_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [31:0]        hi_res;
  logic [31:0]        lo_res;
  logic               res_wr;

  mdu_arith u_arith (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .res_wr (res_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_reg    <= op;
                a_reg     <= src_a;
                b_reg     <= src_b;
                cnt_reg   <= (op == MD_MULT || op == MD_MULTU) ? CNT_W'(MULT_CYCLES)
                                                               : CNT_W'(DIV_CYCLES);
                busy_reg  <= 1'b1;
                state_reg <= BUSY;
              end
              MD_MTHI: hi_reg <= src_a;
              MD_MTLO: lo_reg <= src_a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          // New starts are ignored here; the hazard unit holds them off.
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            if (res_wr) begin
              hi_reg <= hi_res;
              lo_reg <= lo_res;
            end
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall_md = md_use_d & (busy_reg | (start & is_md_op(op)));
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO results, a monitor
// pops them on done and checks busy/done/stall/HI/LO every cycle.
import mdu_pkg::*;

module tb_mdu_ctrl;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        md_use_d = 1'b0;
  logic        busy, done, stall_md;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .md_use_d(md_use_d), .busy(busy), .done(done), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  logic [63:0] exp_q[$];
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        mon_en = 1'b0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if ((o == MD_DIV || o == MD_DIVU) && b == 32'd0) begin
`ifdef MDU_DIVZERO_KEEP_EN
      return {hi_m, lo_m};
`else
      return {a, 32'hFFFF_FFFF};
`endif
    end
    case (o)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU:  return {32'(ua % ub), 32'(ua / ub)};
      default:  return {hi_m, lo_m};
    endcase
  endfunction

  function automatic logic pick_md(input int mode);
    if (mode < 0) return 1'($urandom_range(0, 1));
    return mode[0];
  endfunction

  // Monitor: samples 1 time unit after each falling edge, well away from posedge.
  initial begin
    logic [63:0] e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #1;
      check("busy", {63'b0, busy}, {63'b0, exp_busy});
      check("done", {63'b0, done}, {63'b0, exp_done});
      check("stall_md", {63'b0, stall_md},
            {63'b0, md_use_d & (exp_busy | (start & is_md_op(op)))});
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected at %0t: got done=1 expected no pending result", $time);
        end else begin
          e = exp_q.pop_front();
          check("result_hilo", {hi, lo}, e);
        end
      end
      check("hi_hold", {32'b0, hi}, {32'b0, hi_m});
      check("lo_hold", {32'b0, lo}, {32'b0, lo_m});
    end
  end

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int md_mode, input int abort_at, input bit restart);
    int n;
    logic [63:0] e;
    n = (o == MD_MULT || o == MD_MULTU) ? NM : ND;
    e = ref_result(o, a, b);
    $display("txn op=%0d a=%h b=%h abort_at=%0d restart=%0d expect hi=%h lo=%h",
             o, a, b, abort_at, restart, e[63:32], e[31:0]);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; md_use_d = pick_md(md_mode);
    if (abort_at == 0) exp_q.push_back(e);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      exp_busy = 1'b1;
      start    = restart && (c == 2);
      op       = 3'($urandom_range(0, 3));
      src_a    = $urandom;
      src_b    = $urandom;
      md_use_d = pick_md(md_mode);
      if (c == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; exp_busy = 1'b0; hi_m = '0; lo_m = '0; md_use_d = pick_md(md_mode);
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    start = 1'b0; exp_busy = 1'b0; exp_done = 1'b1; {hi_m, lo_m} = e;
    md_use_d = pick_md(md_mode);
    @(negedge clk);
    exp_done = 1'b0;
  endtask

  task automatic run_simple(input logic [2:0] o, input logic [31:0] a);
    $display("txn op=%0d a=%h (register move / ignored)", o, a);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = $urandom; md_use_d = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    if (o == MD_MTHI) hi_m = a;
    if (o == MD_MTLO) lo_m = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    run_md(MD_MULT,  32'hFFFF_FFFD, 32'd5, 1, 0, 1'b0);
    run_md(MD_DIVU,  32'd100, 32'd7, -1, 0, 1'b0);
    run_md(MD_DIV,   32'hFFFF_FFF9, 32'd2, -1, 0, 1'b0);
    run_md(MD_MULT,  32'h0001_2345, 32'hFFF0_0000, 0, 0, 1'b0);
    run_simple(MD_MTHI, 32'h1234_5678);
    run_simple(MD_MTLO, 32'h9ABC_DEF0);
    run_simple(3'd6, 32'hDEAD_BEEF);
    run_simple(3'd7, 32'hCAFE_F00D);
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1'b1);
    run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 1'b1);
    run_md(MD_DIV,   32'd5, 32'd0, -1, 0, 1'b0);
    run_md(MD_DIVU,  32'hF000_0001, 32'd0, -1, 0, 1'b0);
    run_md(MD_DIV,   32'h7FFF_FFFF, 32'hFFFF_FFFE, -1, 3, 1'b0);
    run_md(MD_MULT,  32'd1, 32'd1, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1, 2:    r_b = 32'($urandom_range(1, 20)) * ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd1);
        default: r_b = $urandom;
      endcase
      if (is_md_op(r_op)) run_md(r_op, r_a, r_b, -1, 0, 1'($urandom_range(0, 1)));
      else                run_simple(r_op, r_a);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
